// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin arbiter for two requesters sharing a MAC datapath, with in-order result routing
module mac_arbiter #(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic               req1_valid,
    output logic               req0_ready,
    output logic               req1_ready,
    input  logic [79:0]        req0_ops,
    input  logic [79:0]        req1_ops,
    output logic               resp0_valid,
    output logic               resp1_valid,
    input  logic               resp0_ready,
    input  logic               resp1_ready,
    output logic signed [31:0] resp_y,
    output logic               dp_in_valid,
    input  logic               dp_in_ready,
    output logic signed [15:0] dp_a,
    output logic signed [15:0] dp_b,
    output logic signed [15:0] dp_c,
    output logic signed [15:0] dp_d,
    output logic signed [15:0] dp_e,
    input  logic               dp_out_valid,
    output logic               dp_out_ready,
    input  logic signed [31:0] dp_y,
    output logic               err
);
    localparam int AW = $clog2(MAX_INFLIGHT);
    logic [MAX_INFLIGHT-1:0] tags;
    logic [AW-1:0]           wptr, rptr;
    logic [AW:0]             count;
    logic                    rr_last, lock, lock_idx, grant, full, empty, head, push, pop;
    // grant selection, issue side and return side handshakes
    always_comb begin
        grant        = lock ? lock_idx : (req0_valid & req1_valid) ? ~rr_last : ~req0_valid;
        full         = count == (AW+1)'(MAX_INFLIGHT);
        empty        = count == '0;
        head         = tags[rptr];
        {dp_a, dp_b, dp_c, dp_d, dp_e} = grant ? req1_ops : req0_ops;
        dp_in_valid  = !rst & (req0_valid | req1_valid) & !full;
        req0_ready   = !rst & dp_in_ready & !full & !grant;
        req1_ready   = !rst & dp_in_ready & !full & grant;
        push         = dp_in_valid & dp_in_ready;
        resp0_valid  = !rst & dp_out_valid & !empty & !head;
        resp1_valid  = !rst & dp_out_valid & !empty & head;
        dp_out_ready = !rst & !empty & (head ? resp1_ready : resp0_ready);
        pop          = dp_out_valid & dp_out_ready;
        resp_y       = dp_y;
    end
    // tag fifo, round-robin pointer, grant lock and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rr_last  <= 1'b1;
            lock     <= 1'b0;
            lock_idx <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (push) begin
                tags[wptr] <= grant;
                wptr       <= wptr + 1'b1;
                rr_last    <= grant;
            end
            if (pop) rptr <= rptr + 1'b1;
            count    <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            lock     <= dp_in_valid & !dp_in_ready;
            lock_idx <= grant;
            err      <= err | (dp_out_valid & empty);
        end
    end
endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter: table-driven arbitration vectors plus scoreboarded result routing for mac_arbiter
module tb_mac_arbiter;
    logic               clk = 0, rst = 1;
    logic               req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [79:0]        req0_ops = '0, req1_ops = '0;
    logic               resp0_valid, resp1_valid, resp0_ready = 1, resp1_ready = 1;
    logic signed [31:0] resp_y;
    logic               dp_in_valid, dp_in_ready = 1;
    logic signed [15:0] dp_a, dp_b, dp_c, dp_d, dp_e;
    logic               dp_out_valid = 0, dp_out_ready;
    logic signed [31:0] dp_y = 0;
    logic               err;
    logic               out_en = 1, spurious = 0;
    int                 checks = 0, errors = 0;

    typedef struct { logic port; int y; } sb_t;
    typedef struct { logic v0, v1, rdy, ev, e0, e1; int eg; } vec_t;
    sb_t  sbq[$];
    int   dpq[$];
    sb_t  e;
    vec_t tbl[14];

    mac_arbiter #(.MAX_INFLIGHT(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_ops(req0_ops), .req1_ops(req1_ops),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .resp_y(resp_y),
        .dp_in_valid(dp_in_valid), .dp_in_ready(dp_in_ready),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d), .dp_e(dp_e),
        .dp_out_valid(dp_out_valid), .dp_out_ready(dp_out_ready), .dp_y(dp_y),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [79:0] pk(int a, int b, int c, int d, int x);
        return {16'(a), 16'(b), 16'(c), 16'(d), 16'(x)};
    endfunction

    function automatic int mac(logic [79:0] o);
        int a, b, c, d, x;
        a = $signed(o[79:64]); b = $signed(o[63:48]); c = $signed(o[47:32]);
        d = $signed(o[31:16]); x = $signed(o[15:0]);
        return a * b + c * d + x;
    endfunction

    task automatic chk(string n, logic signed [63:0] got, logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string n);
        int k = 0;
        while (sbq.size() > 0 && k < 100) begin
            cyc();
            k++;
        end
        chk(n, sbq.size(), 0);
    endtask

    // datapath model: one-cycle latency, results in issue order
    always @(posedge clk) begin
        #2;
        dp_out_valid = (out_en && dpq.size() > 0) || spurious;
        dp_y = dpq.size() > 0 ? dpq[0] : 0;
    end

    // monitor: scoreboard pushes on issue, compares on result handshake
    always @(negedge clk) begin
        if (rst) begin
            dpq.delete();
            sbq.delete();
        end else begin
            if (dp_in_valid && dp_in_ready) begin
                dpq.push_back(mac({dp_a, dp_b, dp_c, dp_d, dp_e}));
                if (req0_ready && req0_valid) sbq.push_back('{1'b0, mac(req0_ops)});
                else if (req1_ready && req1_valid) sbq.push_back('{1'b1, mac(req1_ops)});
                else chk("issue_owner", (req0_ready & req0_valid) | (req1_ready & req1_valid), 1);
            end
            if (dp_out_valid && dp_out_ready) begin
                chk("resp_expected", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("resp_port", {resp1_valid, resp0_valid}, e.port ? 2 : 1);
                    chk("resp_y", resp_y, e.y);
                end
                if (dpq.size() > 0) void'(dpq.pop_front());
            end
        end
    end

    initial begin
        int n;
        tbl = '{
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1},
            '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1},
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2}
        };
        rst = 1;
        req0_valid = 1;
        req1_valid = 1;
        repeat (2) cyc();
        #3;
        chk("rst_dp_in_valid", dp_in_valid, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_resp0_valid", resp0_valid, 0);
        chk("rst_resp1_valid", resp1_valid, 0);
        chk("rst_dp_out_ready", dp_out_ready, 0);
        chk("rst_err", err, 0);
        req0_ops = pk(2, 3, 4, 5, 6);
        req1_ops = pk(1, 1, 1, 1, -1);
        cyc();
        rst = 0;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) cyc();
            req0_valid = tbl[i].v0;
            req1_valid = tbl[i].v1;
            dp_in_ready = tbl[i].rdy;
            #3;
            chk($sformatf("row%0d_in_valid", i), dp_in_valid, tbl[i].ev);
            if (tbl[i].v0 | tbl[i].v1) begin
                chk($sformatf("row%0d_req0_ready", i), req0_ready, tbl[i].e0);
                chk($sformatf("row%0d_req1_ready", i), req1_ready, tbl[i].e1);
            end
            if (tbl[i].eg < 2) chk($sformatf("row%0d_dp_a", i), dp_a, tbl[i].eg == 0 ? 2 : 1);
        end
        drain("table_drain");

        cyc();
        dp_in_ready = 0;
        req1_ops = pk(7, 8, 9, 10, 11);
        req1_valid = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            #3;
            chk("s3_in_valid", dp_in_valid, 1);
            chk("s3_req1_ready_stall", req1_ready, 0);
            chk("s3_dp_a", dp_a, 7);
        end
        cyc();
        req0_valid = 1;
        #3;
        chk("s3_lock_dp_a", dp_a, 7);
        chk("s3_lock_dp_e", dp_e, 11);
        chk("s3_lock_req0_ready", req0_ready, 0);
        cyc();
        dp_in_ready = 1;
        #3;
        chk("s3_accept_req1", req1_ready, 1);
        chk("s3_accept_req0", req0_ready, 0);
        chk("s3_accept_dp_a", dp_a, 7);
        cyc();
        req1_valid = 0;
        #3;
        chk("s3_then_req0", req0_ready, 1);
        cyc();
        req0_valid = 0;
        drain("s3_drain");

        cyc();
        req0_ops = pk(2, 3, 4, 5, 6);
        req0_valid = 1;
        #3;
        chk("s1_issue", req0_ready & dp_in_valid, 1);
        cyc();
        req0_valid = 0;
        #3;
        n = 0;
        while (!resp0_valid && n < 10) begin
            cyc();
            #3;
            n++;
        end
        chk("s1_resp0_valid", resp0_valid, 1);
        chk("s1_resp1_valid", resp1_valid, 0);
        chk("s1_y", resp_y, 32);
        drain("s1_drain");

        cyc();
        resp0_ready = 0;
        req0_ops = pk(3, 3, 0, 0, 1);
        req0_valid = 1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            #3;
            chk("s4_issue", req0_ready & dp_in_valid, 1);
        end
        cyc();
        #3;
        chk("s4_full_in_valid", dp_in_valid, 0);
        chk("s4_full_ready", req0_ready, 0);
        cyc();
        resp0_ready = 1;
        #3;
        chk("s4_pop_out_ready", dp_out_ready, 1);
        chk("s4_pop_still_full", dp_in_valid, 0);
        cyc();
        resp0_ready = 0;
        #3;
        chk("s4_resume_in_valid", dp_in_valid, 1);
        chk("s4_resume_ready", req0_ready, 1);
        cyc();
        req0_valid = 0;
        resp0_ready = 1;
        drain("s4_drain");

        cyc();
        resp0_ready = 0;
        req0_ops = pk(1, 1, 1, 1, -1);
        req0_valid = 1;
        cyc();
        req0_valid = 0;
        req1_ops = pk(-32768, 2, 0, 0, 0);
        req1_valid = 1;
        #3;
        chk("s5_req1_issue", req1_ready & dp_in_valid, 1);
        cyc();
        req1_valid = 0;
        cyc();
        #3;
        chk("s5_resp1_blocked", resp1_valid, 0);
        chk("s5_resp0_waiting", resp0_valid, 1);
        chk("s5_out_ready_held", dp_out_ready, 0);
        chk("s5_y_head", resp_y, 1);
        cyc();
        resp0_ready = 1;
        #3;
        chk("s5_out_ready", dp_out_ready, 1);
        cyc();
        #3;
        chk("s5_resp1_valid", resp1_valid, 1);
        chk("s5_y_second", resp_y, -65536);
        drain("s5_drain");

        cyc();
        spurious = 1;
        #3;
        chk("s6_spurious_out_ready", dp_out_ready, 0);
        cyc();
        spurious = 0;
        #3;
        chk("s6_err_set", err, 1);
        cyc();
        #3;
        chk("s6_err_held", err, 1);
        cyc();
        out_en = 0;
        req0_valid = 1;
        req1_valid = 1;
        cyc();
        cyc();
        rst = 1;
        #3;
        chk("s6_rst_in_valid", dp_in_valid, 0);
        chk("s6_rst_req_ready", req0_ready | req1_ready, 0);
        chk("s6_rst_resp_valid", resp0_valid | resp1_valid, 0);
        chk("s6_rst_out_ready", dp_out_ready, 0);
        cyc();
        #3;
        chk("s6_rst_err", err, 0);
        cyc();
        rst = 0;
        out_en = 1;
        #3;
        chk("s6_in_valid", dp_in_valid, 1);
        chk("s6_first_req0", req0_ready, 1);
        chk("s6_first_req1", req1_ready, 0);
        chk("s6_no_stale_resp", resp0_valid | resp1_valid, 0);
        chk("s6_err_after", err, 0);
        cyc();
        req0_valid = 0;
        req1_valid = 0;
        drain("s6_drain");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_INFLIGHT, default 4, which is the maximum number of datapath transactions in flight and the tag FIFO depth (power of 2, 2..16).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 each, requester operand-valid.
REQ-005 The block SHALL have ports req0_ready / req1_ready, output, 1 each, requester operand accepted.
REQ-006 The block SHALL have ports req0_ops / req1_ops, input, 80 each, packed signed {a,b,c,d,e}, 16 bits each, a in [79:64].
REQ-007 The block SHALL have ports resp0_valid / resp1_valid, output, 1 each, result valid for that requester.
REQ-008 The block SHALL have ports resp0_ready / resp1_ready, input, 1 each, requester accepts result.
REQ-009 The block SHALL have port resp_y, output, 32, signed result shared by both response ports.
REQ-010 The block SHALL have ports dp_in_valid (output, 1), dp_in_ready (input, 1) and dp_a..dp_e (output, 16 signed each), forming the issue side of the MAC datapath y=a*b+c*d+e.
REQ-011 The block SHALL have ports dp_out_valid (input, 1), dp_out_ready (output, 1) and dp_y (input, 32 signed), forming the return side of the datapath.
REQ-012 The block SHALL have port err, output, 1, sticky protocol-error flag.

Function
REQ-013 Arbitration SHALL be 2-way round-robin: when both requesters are valid, the one not granted on the last accepted issue wins; a sole valid requester SHALL win immediately.
REQ-014 dp_in_valid SHALL equal (req0_valid | req1_valid) & !fifo_full; dp_a..dp_e SHALL be the granted requester's operands, combinational, with zero added latency.
REQ-015 reqN_ready SHALL equal dp_in_ready & !fifo_full & (grant==N); the non-granted requester's ready SHALL be 0.
REQ-016 Grant lock: if dp_in_valid=1 and dp_in_ready=0, the grant SHALL be registered and held on following cycles until the issue is accepted, even if the other requester becomes valid; the lock SHALL clear on acceptance.
REQ-017 On each issue handshake (dp_in_valid & dp_in_ready), the grant index SHALL be pushed into a MAX_INFLIGHT-deep tag FIFO, and the round-robin pointer SHALL update to that index.
REQ-018 fifo_full SHALL block issue even if a pop occurs in the same cycle; a simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-019 respN_valid SHALL equal dp_out_valid & !fifo_empty & (head_tag==N); resp_y SHALL equal dp_y.
REQ-020 dp_out_ready SHALL equal !fifo_empty & respN_ready, where N=head_tag; the FIFO SHALL pop on dp_out_valid & dp_out_ready.
REQ-021 Results SHALL return in issue order; a stalled head requester SHALL stall the other requester's results (no reordering).
REQ-022 dp_out_valid=1 while fifo_empty SHALL set err, which SHALL stay set until reset; dp_out_ready SHALL stay 0 in that case.
REQ-023 FIFO read/write pointers SHALL wrap modulo MAX_INFLIGHT; the occupancy counter SHALL be width clog2(MAX_INFLIGHT)+1.

Reset
REQ-024 While rst=1, the FIFO SHALL be empty, the lock cleared, the round-robin pointer set so that req0 wins the first contention, and err SHALL be 0.
REQ-025 Outputs under reset SHALL be: dp_in_valid=0, reqN_ready=0, respN_valid=0, dp_out_ready=0; reset mid-operation SHALL discard all in-flight tags.

Verification
REQ-026 Scenario 1: req0 only, ops {2,3,4,5,6}, datapath ready -> issue accepted in the same cycle; resp0 y=32 after datapath latency; resp1_valid never asserted.
REQ-027 Scenario 2: both requesters valid continuously for 6 issues -> grants alternate 0,1,0,1,0,1 starting with 0; results are routed to the matching ports in order.
REQ-028 Scenario 3: dp_in_ready=0 for 3 cycles with req1 granted, then req0 rises -> grant stays 1 and dp operands stay stable; req1 is accepted when ready rises.
REQ-029 Scenario 4: datapath out_ready held off by resp0_ready=0 while 4 issues are in flight -> dp_in_valid=0 at full; after one pop, issue resumes on the next cycle.
REQ-030 Scenario 5: head tag=0, resp0_ready=0, next tag=1 -> resp1_valid stays 0 until resp0 completes; then y values are delivered in order, e.g. {1,1,1,1,-1} -> 1 and {-32768,2,0,0,0} -> -65536.
REQ-031 Scenario 6: dp_out_valid=1 with empty FIFO -> err=1 and held; assert rst with 2 tags in flight -> FIFO empty, err=0, first contention granted to req0.
